// File: rtl/dvi_encoder.sv
// DVI TMDS encoder: expands 4-bit RGB to 8 bits and emits three 10-bit TMDS symbols.
// Stage 1 builds the transition-minimised q_m; stage 2 applies DC balancing or control tokens.
module dvi_encoder #(
    parameter bit HSYNC_ACTIVE_LOW = 1'b1,
    parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] vga_r,
    input  logic [3:0] vga_g,
    input  logic [3:0] vga_b,
    input  logic       vga_hsync,
    input  logic       vga_vsync,
    input  logic       vga_de,
    output logic [9:0] tmds_ch0,
    output logic [9:0] tmds_ch1,
    output logic [9:0] tmds_ch2
);

    localparam logic [9:0] TokCtl00 = 10'b1101010100;
    localparam logic [9:0] TokCtl01 = 10'b0010101011;
    localparam logic [9:0] TokCtl10 = 10'b0101010100;
    localparam logic [9:0] TokCtl11 = 10'b1010101011;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [8:0] transition_min(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] qm;
        n1       = popcount8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        qm       = '0;
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        end
        qm[8] = ~use_xnor;
        return qm;
    endfunction

    // Returns {next_cnt, symbol}; diff is N1 - N0 of q_m[7:0].
    function automatic logic [15:0] balance(input logic [8:0] qm, input logic signed [5:0] cnt);
        logic [3:0]        n1;
        logic signed [5:0] diff;
        logic signed [5:0] bias;
        logic signed [5:0] cnt_n;
        logic [9:0]        sym;
        n1   = popcount8(qm[7:0]);
        diff = $signed({1'b0, n1, 1'b0}) - 6'sd8;
        bias = qm[8] ? 6'sd2 : 6'sd0;
        if ((cnt == 6'sd0) || (n1 == 4'd4)) begin
            sym   = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            cnt_n = qm[8] ? (cnt + diff) : (cnt - diff);
        end else if (((cnt > 6'sd0) && (n1 > 4'd4)) || ((cnt < 6'sd0) && (n1 < 4'd4))) begin
            sym   = {1'b1, qm[8], ~qm[7:0]};
            cnt_n = cnt + bias - diff;
        end else begin
            sym   = {1'b0, qm[8], qm[7:0]};
            cnt_n = cnt + diff - (6'sd2 - bias);
        end
        return {cnt_n, sym};
    endfunction

    function automatic logic [9:0] control_token(input logic [1:0] ctl);
        logic [9:0] tok;
        unique case (ctl)
            2'b00:   tok = TokCtl00;
            2'b01:   tok = TokCtl01;
            2'b10:   tok = TokCtl10;
            default: tok = TokCtl11;
        endcase
        return tok;
    endfunction

    // Channel order matches the outputs: 0 = blue, 1 = green, 2 = red.
    logic [2:0][7:0] pix;
    logic            hsync_act;
    logic            vsync_act;

    assign pix[0]    = {vga_b, vga_b};
    assign pix[1]    = {vga_g, vga_g};
    assign pix[2]    = {vga_r, vga_r};
    assign hsync_act = HSYNC_ACTIVE_LOW ? ~vga_hsync : vga_hsync;
    assign vsync_act = VSYNC_ACTIVE_LOW ? ~vga_vsync : vga_vsync;

    logic [2:0][8:0] qm_d, qm_q;
    logic            de_q, hsync_q, vsync_q;

    always_comb begin
        qm_d = '0;
        for (int c = 0; c < 3; c++) begin
            qm_d[c] = transition_min(pix[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            qm_q    <= '0;
            de_q    <= 1'b0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            qm_q    <= qm_d;
            de_q    <= vga_de;
            hsync_q <= hsync_act;
            vsync_q <= vsync_act;
        end
    end

    logic [2:0][9:0] sym_d, sym_q;
    logic [2:0][5:0] cnt_d, cnt_q;

    always_comb begin
        sym_d = '0;
        cnt_d = '0;
        for (int c = 0; c < 3; c++) begin
            if (de_q) begin
                {cnt_d[c], sym_d[c]} = balance(qm_q[c], $signed(cnt_q[c]));
            end else begin
                cnt_d[c] = '0;
                sym_d[c] = TokCtl00;
            end
        end
        // Only the blue channel carries the sync controls during blanking.
        if (!de_q) begin
            sym_d[0] = control_token({vsync_q, hsync_q});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sym_q <= {3{TokCtl00}};
            cnt_q <= '0;
        end else begin
            sym_q <= sym_d;
            cnt_q <= cnt_d;
        end
    end

    assign tmds_ch0 = sym_q[0];
    assign tmds_ch1 = sym_q[1];
    assign tmds_ch2 = sym_q[2];

endmodule

// File: tb/tb_dvi_encoder.sv
// Self-checking bench for dvi_encoder: directed vector table, mid-run reset sequence,
// and a randomised stream compared against a behavioural TMDS model.
module tb_dvi_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       vga_hsync, vga_vsync, vga_de;
    logic [9:0] tmds_ch0, tmds_ch1, tmds_ch2;

    always #5 clk = ~clk;

    dvi_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .vga_r     (vga_r),
        .vga_g     (vga_g),
        .vga_b     (vga_b),
        .vga_hsync (vga_hsync),
        .vga_vsync (vga_vsync),
        .vga_de    (vga_de),
        .tmds_ch0  (tmds_ch0),
        .tmds_ch1  (tmds_ch1),
        .tmds_ch2  (tmds_ch2)
    );

    int checks   = 0;
    int failures = 0;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100;
    localparam logic [9:0] T11 = 10'b1010101011;

    // hs/vs are "sync active" flags; pins are active-low with default parameters.
    typedef struct {
        logic [3:0] r, g, b;
        logic       de, hs, vs;
        logic [9:0] e0, e1, e2;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic logic [29:0] outs();
        return {tmds_ch0, tmds_ch1, tmds_ch2};
    endfunction

    task automatic check(input string name, input logic [29:0] got, input logic [29:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: ch0/ch1/ch2 got %b/%b/%b expected %b/%b/%b", name,
                     got[29:20], got[19:10], got[9:0], exp[29:20], exp[19:10], exp[9:0]);
        end
    endtask

    task automatic check_bound(input string name, input int val);
        checks++;
        if (val > 10 || val < -10) begin
            failures++;
            $display("FAIL %s: running disparity got %0d required within -10..10", name, val);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                         input logic de, input logic hs, input logic vs);
        vga_r     = r;
        vga_g     = g;
        vga_b     = b;
        vga_de    = de;
        vga_hsync = ~hs;
        vga_vsync = ~vs;
    endtask

    // Reference TMDS data encoder written directly from the integer definitions.
    task automatic model_pixel(input logic [3:0] c, input int cnt_in,
                               output logic [9:0] sym, output int cnt_out);
        logic [7:0] d, m;
        int         ones, n1, n0, m8;
        bit         xn;
        d    = {c, c};
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        xn   = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        m    = '0;
        m[0] = d[0];
        for (int i = 1; i < 8; i++) m[i] = xn ? (m[i-1] == d[i]) : (m[i-1] != d[i]);
        m8 = xn ? 0 : 1;
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += int'(m[i]);
        n0 = 8 - n1;
        cnt_out = cnt_in;
        if (cnt_in == 0 || n1 == n0) begin
            sym     = (m8 == 1) ? {2'b01, m} : {2'b10, ~m};
            cnt_out = cnt_in + ((m8 == 1) ? (n1 - n0) : (n0 - n1));
        end else if ((cnt_in > 0 && n1 > n0) || (cnt_in < 0 && n0 > n1)) begin
            sym     = {1'b1, m8[0], ~m};
            cnt_out = cnt_in + 2 * m8 + n0 - n1;
        end else begin
            sym     = {1'b0, m8[0], m};
            cnt_out = cnt_in + n1 - n0 - 2 * (1 - m8);
        end
    endtask

    initial begin
        vecs[0]  = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, T00, T00, T00};
        vecs[1]  = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, T01, T00, T00};
        vecs[2]  = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, T10, T00, T00};
        vecs[3]  = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, T11, T00, T00};
        vecs[4]  = '{4'h5, 4'hA, 4'h1, 1'b1, 1'b0, 1'b0, 10'h10F, 10'h233, 10'h133};
        vecs[5]  = '{4'h0, 4'hF, 4'h3, 1'b1, 1'b1, 1'b0, 10'h111, 10'h200, 10'h100};
        vecs[6]  = '{4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 10'h3FF};
        vecs[7]  = '{4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 10'h200, 10'h200, 10'h200};
        vecs[8]  = '{4'h3, 4'h5, 4'hA, 1'b1, 1'b0, 1'b1, 10'h233, 10'h133, 10'h3EE};
        vecs[9]  = '{4'h1, 4'h1, 4'h1, 1'b1, 1'b0, 1'b0, 10'h10F, 10'h10F, 10'h10F};
        vecs[10] = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, T00, T00, T00};
        vecs[11] = '{4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 10'h100, 10'h100, 10'h100};
        vecs[12] = '{4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 10'h0FF, 10'h3FF, 10'h3FF};
        vecs[13] = '{4'h3, 4'h3, 4'h0, 1'b1, 1'b0, 1'b0, 10'h3FF, 10'h111, 10'h111};
        vecs[14] = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, T01, T00, T00};
        vecs[15] = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, T00, T00, T00};
        vecs[16] = '{4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 10'h100, 10'h100, 10'h100};
        vecs[17] = '{4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 10'h3FF};
        vecs[18] = '{4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 10'h100, 10'h100, 10'h100};
        vecs[19] = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, T00, T00, T00};

        // Reset state and idle blanking.
        reset = 1'b1;
        drive(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_hold%0d", i), outs(), {T00, T00, T00});
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("idle_blank%0d", i), outs(), {T00, T00, T00});
        end

        // Streamed vector table; each entry is visible two edges after it is driven.
        for (int k = 0; k < NV + 2; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                check($sformatf("vec%0d", k - 2), outs(),
                      {vecs[k-2].e0, vecs[k-2].e1, vecs[k-2].e2});
            end
            if (k < NV) begin
                drive(vecs[k].r, vecs[k].g, vecs[k].b, vecs[k].de, vecs[k].hs, vecs[k].vs);
            end else begin
                drive(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
            end
        end

        // One-cycle reset in the middle of an active black run.
        drive(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrun_reset", outs(), {T00, T00, T00});
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_blank", outs(), {T00, T00, T00});
        @(negedge clk);
        check("resume_px0", outs(), {3{10'h100}});
        @(negedge clk);
        check("resume_px1", outs(), {3{10'h3FF}});
        @(negedge clk);
        check("resume_px2", outs(), {3{10'h100}});

        // Randomised stream against the model, with a running-disparity bound on the outputs.
        drive(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        begin
            int         mcnt [3];
            int         acc  [3];
            logic [29:0] hist [2];
            logic        hist_de [2];
            logic        de_r;
            logic [3:0]  col [3];
            logic        hs_r, vs_r;
            logic [9:0]  sym [3];
            logic [29:0] got;
            for (int c = 0; c < 3; c++) begin
                mcnt[c] = 0;
                acc[c]  = 0;
            end
            hist[0]    = {T00, T00, T00};
            hist[1]    = {T00, T00, T00};
            hist_de[0] = 1'b0;
            hist_de[1] = 1'b0;
            de_r       = 1'b0;
            for (int k = 0; k < 1500; k++) begin
                @(negedge clk);
                got = outs();
                check($sformatf("rand%0d", k), got, hist[0]);
                for (int c = 0; c < 3; c++) begin
                    if (hist_de[0]) begin
                        acc[c] += 2 * $countones(got[(2-c)*10 +: 10]) - 10;
                        check_bound($sformatf("rand%0d_ch%0d_disp", k, c), acc[c]);
                    end else begin
                        acc[c] = 0;
                    end
                end
                if ($urandom_range(0, 7) == 0) de_r = ~de_r;
                col[0] = 4'($urandom_range(0, 15));
                col[1] = 4'($urandom_range(0, 15));
                col[2] = 4'($urandom_range(0, 15));
                hs_r   = ($urandom_range(0, 3) == 0);
                vs_r   = ($urandom_range(0, 5) == 0);
                drive(col[2], col[1], col[0], de_r, hs_r, vs_r);
                for (int c = 0; c < 3; c++) begin
                    if (de_r) begin
                        model_pixel(col[c], mcnt[c], sym[c], mcnt[c]);
                    end else begin
                        mcnt[c] = 0;
                        sym[c]  = T00;
                    end
                end
                if (!de_r) begin
                    case ({vs_r, hs_r})
                        2'b00:   sym[0] = T00;
                        2'b01:   sym[0] = T01;
                        2'b10:   sym[0] = T10;
                        default: sym[0] = T11;
                    endcase
                end
                hist[0]    = hist[1];
                hist_de[0] = hist_de[1];
                hist[1]    = {sym[0], sym[1], sym[2]};
                hist_de[1] = de_r;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
